// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and default frame constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam int DEF_CLKS_PER_BIT = 5208;
    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_STOP_BITS = 1;
endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: start/data handshake and serial outputs of the TX serializer
interface uart_tx_core_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic                 tx_start_i;
    logic [DATA_BITS-1:0] data_i;
    logic                 tx_o;
    logic                 tx_done_o;
    logic                 busy_o;
    modport master (output tx_start_i, data_i, input tx_o, tx_done_o, busy_o);
    modport slave (input tx_start_i, data_i, output tx_o, tx_done_o, busy_o);
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: free-running bit-period counter with a bit-end tick
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    output logic bit_end
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt;
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    // count 0..CLKS_PER_BIT-1, wrap on the tick, hold at zero while cleared
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt <= '0;
        else cnt <= (clear || bit_end) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: LSB-first UART frame serializer with optional even parity
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = DEF_STOP_BITS
) (
    input logic          clk_i,
    input logic          rst_i,
    uart_tx_core_if.slave bus
);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;
    logic [2:0]           state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic                 par, par_n, done_n, tx_n, bit_end;
    uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i(clk_i), .rst_i(rst_i), .clear(state == ST_IDLE), .bit_end(bit_end)
    );
    // next-state, shift and counter logic; tx is derived from the next state so the line is registered
    always_comb begin
        state_n = state;
        shift_n = shift;
        par_n   = par;
        bit_n   = bit_cnt;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: if (bus.tx_start_i) begin
                state_n = ST_START;
                shift_n = bus.data_i;
                par_n   = ^bus.data_i;
                bit_n   = '0;
            end
            ST_START: if (bit_end) state_n = ST_DATA;
            ST_DATA: if (bit_end) begin
                shift_n = shift >> 1;
                bit_n   = (bit_cnt == BW'(DATA_BITS - 1)) ? '0 : bit_cnt + BW'(1);
                state_n = (bit_cnt != BW'(DATA_BITS - 1)) ? ST_DATA : (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (bit_end) state_n = ST_STOP;
            ST_STOP: if (bit_end) begin
                done_n  = bit_cnt == BW'(STOP_BITS - 1);
                bit_n   = done_n ? '0 : bit_cnt + BW'(1);
                state_n = done_n ? ST_IDLE : ST_STOP;
            end
            default: state_n = ST_IDLE;
        endcase
        tx_n = (state_n == ST_START) ? 1'b0 : (state_n == ST_DATA) ? shift_n[0] :
               (state_n == ST_PARITY) ? par_n : 1'b1;
    end
    // state registers; reset drives the line idle-high immediately
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state         <= ST_IDLE;
            shift         <= '0;
            bit_cnt       <= '0;
            par           <= 1'b0;
            bus.tx_o      <= 1'b1;
            bus.tx_done_o <= 1'b0;
        end else begin
            state         <= state_n;
            shift         <= shift_n;
            bit_cnt       <= bit_n;
            par           <= par_n;
            bus.tx_o      <= tx_n;
            bus.tx_done_o <= done_n;
        end
    assign bus.busy_o = state != ST_IDLE;
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed frame checks on three parameterisations of the serializer
module tb_uart_tx_core;
    localparam int CPB = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start[3];
    logic [7:0] data[3];
    logic       tx[3], done[3], busy[3];
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int          d;
        logic [7:0]  dat;
        logic [15:0] exp;
        int          nb;
    } vec_t;
    vec_t v[7];

    always #5 clk = ~clk;

    uart_tx_core_if #(.DATA_BITS(8)) if0();
    uart_tx_core_if #(.DATA_BITS(8)) if1();
    uart_tx_core_if #(.DATA_BITS(8)) if2();
    uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1))
        u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1))
        u1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2))
        u2 (.clk_i(clk), .rst_i(rst), .bus(if2));

    assign if0.tx_start_i = start[0];
    assign if1.tx_start_i = start[1];
    assign if2.tx_start_i = start[2];
    assign if0.data_i = data[0];
    assign if1.data_i = data[1];
    assign if2.data_i = data[2];
    assign tx[0] = if0.tx_o;
    assign tx[1] = if1.tx_o;
    assign tx[2] = if2.tx_o;
    assign done[0] = if0.tx_done_o;
    assign done[1] = if1.tx_done_o;
    assign done[2] = if2.tx_done_o;
    assign busy[0] = if0.busy_o;
    assign busy[1] = if1.busy_o;
    assign busy[2] = if2.busy_o;

    function automatic void chk(string n, logic a, logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endfunction

    // Called just after a negedge: strobes start, then checks every cycle 1..F+1.
    // inj>0 pulses a 0x3C start in cycle inj; hold keeps start high after acceptance.
    task automatic run_frame(input int d, input logic [7:0] dat, input logic [15:0] exp,
                             input int nb, input int inj, input logic hold, input logic [7:0] nxt);
        int f = nb * CPB;
        start[d] = 1'b1;
        data[d] = dat;
        @(posedge clk);
        for (int c = 1; c <= f + 1; c++) begin
            @(negedge clk);
            chk($sformatf("tx d%0d %02h c%0d", d, dat, c), tx[d], c <= f ? exp[(c - 1) / CPB] : 1'b1);
            chk($sformatf("busy d%0d %02h c%0d", d, dat, c), busy[d], c <= f);
            chk($sformatf("done d%0d %02h c%0d", d, dat, c), done[d], c == f + 1);
            if (c == 1) begin
                start[d] = hold;
                data[d] = nxt;
            end
            if (inj > 0 && c == inj - 1) begin
                start[d] = 1'b1;
                data[d] = 8'h3C;
            end
            if (inj > 0 && c == inj) start[d] = 1'b0;
        end
    endtask

    initial begin
        logic ok;
        v[0] = '{0, 8'hA5, 16'h034A, 10};
        v[1] = '{0, 8'h00, 16'h0200, 10};
        v[2] = '{0, 8'hFF, 16'h03FE, 10};
        v[3] = '{0, 8'h55, 16'h02AA, 10};
        v[4] = '{1, 8'h07, 16'h060E, 11};
        v[5] = '{1, 8'h03, 16'h0406, 11};
        v[6] = '{2, 8'h01, 16'h0602, 11};
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            data[i] = 8'h00;
        end
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset tx d%0d", i), tx[i], 1'b1);
            chk($sformatf("reset busy d%0d", i), busy[i], 1'b0);
            chk($sformatf("reset done d%0d", i), done[i], 1'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 7; i++)
            run_frame(v[i].d, v[i].dat, v[i].exp, v[i].nb, 0, 1'b0, 8'h00);
        run_frame(0, 8'hA5, 16'h034A, 10, 10, 1'b0, 8'h00);
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) ok = 1'b0;
        end
        chk("no queued frame after busy start", ok, 1'b1);
        @(negedge clk);
        start[0] = 1'b1;
        data[0] = 8'hA5;
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) start[0] = 1'b0;
        end
        chk("tx low before mid reset", tx[0], 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("mid reset tx async", tx[0], 1'b1);
        chk("mid reset busy async", busy[0], 1'b0);
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || tx[0] !== 1'b1) ok = 1'b0;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) ok = 1'b0;
        end
        chk("no done after mid reset", ok, 1'b1);
        run_frame(0, 8'h55, 16'h02AA, 10, 0, 1'b0, 8'h00);
        run_frame(2, 8'h01, 16'h0602, 11, 0, 1'b1, 8'h80);
        run_frame(2, 8'h80, 16'h0700, 11, 0, 1'b0, 8'h00);
        @(negedge clk);
        chk("b2b idle after second frame", busy[2], 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
